display_buffer_controller: RTL
==============================

Name: display_buffer_controller

Overview:
- Double-buffered framebuffer controller that sits between a pixel writer (frame source) and display_driver.
- Serves the driver's {row, column} pixel reads from the front bank and accepts a raster-order pixel stream into the back bank.
- Swaps banks only on the driver's frame_complete pulse, so a frame is never torn mid-scan.

Parameters:
- rows, 8, rows scanned by the driver; power of two.
- columns, 32, columns per row; power of two.
- bitwidth, 8, bits per colour channel; pixel width is 3*bitwidth.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-low reset.
- row  input  log2(rows)  driver read row.
- column  input  log2(columns)  driver read column.
- pixel  output  3*bitwidth  front-bank pixel at {row, column}, registered.
- frame_complete  input  1  one-cycle pulse from the driver; marks the safe flip point.
- wr_valid  input  1  writer pixel valid.
- wr_ready  output  1  controller can accept a pixel.
- wr_data  input  3*bitwidth  pixel, {R,G,B}, R in the MSBs.
- wr_last  input  1  final pixel of the frame; qualified by wr_valid && wr_ready.
- flip_pending  output  1  back frame complete, awaiting frame_complete.
- front  output  1  index of the bank being displayed.

Behaviour:
- Reset (rst==0 at posedge clk), also valid mid-operation:
  - state=FILL, front=0, write address=0, pixel=0, flip_pending=0, wr_ready=0 in the reset cycle.
  - RAM contents are not cleared.
- Read path:
  - pixel <= bank[front][{row, column}] every cycle.
  - Latency exactly 1 cycle; this is what display_driver expects of its pixel source.
  - Bank index for the read is sampled in the same cycle as the address.
- Write accept: a pixel is accepted when wr_valid && wr_ready.
  - It is written to bank[!front] at address waddr, then waddr increments.
  - waddr is log2(rows*columns) bits; row-major, address = {row, column}.
- FILL state:
  - wr_ready=1.
  - Accepted pixel with wr_last=1: waddr->0, state->PENDING.
  - waddr wraps from rows*columns-1 to 0 without wr_last: stays in FILL; the next pixel overwrites address 0.
  - wr_last before a full frame: the unwritten back-bank addresses keep their previous contents.
- PENDING state:
  - wr_ready=0, flip_pending=1.
  - On frame_complete=1: front<=!front, state->FILL, flip_pending->0.
  - The new front is visible in pixel starting 2 cycles after the frame_complete edge.
- Simultaneous events:
  - frame_complete in the same cycle as the accepted wr_last is ignored (state was FILL); the flip waits for the next pulse.
  - frame_complete during FILL has no effect.
- No combinational path from wr_valid to wr_ready; wr_ready is a function of state only.
- Read and write never target the same bank, so no read/write collision handling is needed.

Optional Feature:
- Macro: DISPLAY_BUFFER_FLIP_COUNT_EN.
- When defined: extra output flip_count [7:0], reset 0, increments by 1 on every bank swap, wraps 255->0.
- When undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package (display_pkg): state encoding (FILL=1'b0, PENDING=1'b1) and pixel-width / address-width helper constants derived from rows, columns, bitwidth.
- One sub-module, display_buffer_bank: simple dual-port RAM with 1 write port and 1 registered read port.
  - Depth rows*columns, width 3*bitwidth.
  - Instantiated twice; the controller muxes the read data by front and gates the write enables by !front.

Test Plan:
- Reset: hold rst=0 for 3 cycles, release -> front=0, flip_pending=0, pixel=0, wr_ready=1 on the first cycle after release.
- Full frame + flip: stream 256 pixels (address 0 = 24'hff0000, rest 0), wr_last on the 256th -> flip_pending=1, wr_ready=0. Pulse frame_complete -> front=1, and 2 cycles later row=0/column=0 reads 24'hff0000.
- Read latency: after the flip, drive row=3, column=17 with a written 24'h00ff00 -> pixel==24'h00ff00 exactly 1 cycle later.
- Simultaneous: wr_last accepted in the same cycle as a frame_complete pulse -> front unchanged, flip_pending=1. Next frame_complete -> front toggles.
- Partial frame and wrap:
  - wr_last after 10 pixels -> after the flip, addresses 10..255 show the old back-bank data.
  - 258 pixels without wr_last -> addresses 0..1 hold pixels 256..257.
- Mid-operation reset: assert rst=0 in PENDING with front=1 -> front=0, state FILL, flip_pending=0. With DISPLAY_BUFFER_FLIP_COUNT_EN, also flip_count=0.

Source files
------------

// File: rtl/display_pkg.sv
// Shared state encoding and width helpers for the double-buffered display controller.
package display_pkg;

  typedef enum logic {
    FILL    = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam int unsigned ROWS     = 8;
  localparam int unsigned COLUMNS  = 32;
  localparam int unsigned BITWIDTH = 8;

  function automatic int unsigned pixel_width(input int unsigned bitwidth);
    return 3 * bitwidth;
  endfunction

  function automatic int unsigned addr_width(input int unsigned rows, input int unsigned columns);
    return $clog2(rows * columns);
  endfunction

  localparam int unsigned PIXEL_W = pixel_width(BITWIDTH);
  localparam int unsigned ADDR_W  = addr_width(ROWS, COLUMNS);

endpackage

// File: rtl/display_buffer_bank.sv
// Simple dual-port pixel RAM: one write port, one registered read port.
module display_buffer_bank #(
  parameter int unsigned depth  = 256,
  parameter int unsigned width  = 24,
  parameter int unsigned addr_w = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [addr_w-1:0] waddr,
  input  logic [width-1:0]  wdata,
  input  logic [addr_w-1:0] raddr,
  output logic [width-1:0]  rdata
);

  logic [width-1:0] mem [depth];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register resets; array contents survive reset.
  always_ff @(posedge clk) begin
    if (!rst) rdata <= '0;
    else      rdata <= mem[raddr];
  end

endmodule

// File: rtl/display_buffer_controller.sv
// Double-buffered framebuffer controller; banks flip only on frame_complete.
// Optional DISPLAY_BUFFER_FLIP_COUNT_EN adds an 8-bit flip_count output.
module display_buffer_controller
  import display_pkg::*;
#(
  parameter int unsigned rows     = ROWS,
  parameter int unsigned columns  = COLUMNS,
  parameter int unsigned bitwidth = BITWIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(rows)-1:0]       row,
  input  logic [$clog2(columns)-1:0]    column,
  output logic [3*bitwidth-1:0]         pixel,
  input  logic                          frame_complete,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [3*bitwidth-1:0]         wr_data,
  input  logic                          wr_last,
  output logic                          flip_pending,
`ifdef DISPLAY_BUFFER_FLIP_COUNT_EN
  output logic [7:0]                    flip_count,
`endif
  output logic                          front
);

  localparam int unsigned PW    = pixel_width(bitwidth);
  localparam int unsigned AW    = addr_width(rows, columns);
  localparam int unsigned DEPTH = rows * columns;

  state_t          state, state_n;
  logic            front_n;
  logic [AW-1:0]   waddr, waddr_n;
  logic            accept;
  logic            front_rd;
  logic [AW-1:0]   raddr;
  logic [PW-1:0]   rdata0, rdata1;

  assign raddr  = {row, column};
  assign accept = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= FILL;
      front    <= 1'b0;
      waddr    <= '0;
      front_rd <= 1'b0;
    end else begin
      state    <= state_n;
      front    <= front_n;
      waddr    <= waddr_n;
      front_rd <= front;
    end
  end

  always_comb begin
    state_n      = state;
    front_n      = front;
    waddr_n      = waddr;
    wr_ready     = 1'b0;
    flip_pending = 1'b0;
    unique case (state)
      FILL: begin
        wr_ready = rst;
        if (accept) begin
          if (wr_last) begin
            waddr_n = '0;
            state_n = PENDING;
          end else begin
            waddr_n = waddr + 1'b1;
          end
        end
      end
      PENDING: begin
        flip_pending = 1'b1;
        if (frame_complete) begin
          front_n = !front;
          state_n = FILL;
        end
      end
      default: state_n = FILL;
    endcase
  end

`ifdef DISPLAY_BUFFER_FLIP_COUNT_EN
  always_ff @(posedge clk) begin
    if (!rst)                            flip_count <= '0;
    else if (state == PENDING && frame_complete) flip_count <= flip_count + 8'd1;
  end
`endif

  display_buffer_bank #(.depth(DEPTH), .width(PW), .addr_w(AW)) u_bank0 (
    .clk(clk), .rst(rst), .we(accept && front), .waddr(waddr), .wdata(wr_data),
    .raddr(raddr), .rdata(rdata0)
  );

  display_buffer_bank #(.depth(DEPTH), .width(PW), .addr_w(AW)) u_bank1 (
    .clk(clk), .rst(rst), .we(accept && !front), .waddr(waddr), .wdata(wr_data),
    .raddr(raddr), .rdata(rdata1)
  );

  // Bank select travels with the address so the flip lands on a clean read boundary.
  assign pixel = front_rd ? rdata1 : rdata0;

endmodule
